output_arbiter: RTL and testbench

- Output-side counterpart of the per-input route stage. One instance per output port.
- Collects flits that the four direction VC buffers have routed to this port, and arbitrates round-robin on head flits.
- Holds the granted input until its tail flit has passed (wormhole lock).
- Drives the output link under credit-based flow control toward the downstream input buffer.

---
 rtl/output_arbiter_if.sv | 36 +++
 rtl/output_arbiter.sv | 117 +++++++++++
 tb/tb_output_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/output_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : output_arbiter_if
// Brief    : Request/grant, output link and credit signals of one output port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface output_arbiter_if #(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 8,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_IN-1:0]        req;
  logic [NUM_IN*FLIT_W-1:0] flit_in;
  logic [NUM_IN-1:0]        grant;
  logic [FLIT_W-1:0]        flit_out;
  logic                     flit_valid;
  logic                     credit_in;
  logic [CW-1:0]            credit_cnt;

  // Buffers and downstream link side.
  modport master (
    output req, flit_in, credit_in,
    input  grant, flit_out, flit_valid, credit_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, flit_in, credit_in,
    output grant, flit_out, flit_valid, credit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/output_arbiter.sv
//------------------------------------------------------------------------------
// Module   : output_arbiter
// Brief    : Round-robin wormhole arbiter with credit flow control, one per port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module output_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 8,
  parameter int CREDITS = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  output_arbiter_if.slave   bus
);
  localparam int OW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] C_CREDIT_MAX = CW'(CREDITS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  logic [OW-1:0]     r_owner;
  logic [OW-1:0]     r_rr_ptr;
  logic [CW-1:0]     r_credit;
  logic [FLIT_W-1:0] r_flit_out;
  logic              r_flit_valid;

  logic              w_found;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_next_ptr;
  logic [FLIT_W-1:0] w_flit;
  logic [NUM_IN-1:0] w_grant;
  logic              w_is_tail;
  int                w_idx;

  // Type bit FLIT_W-2 set = head/single (opens a packet); bit FLIT_W-1 set = tail/single.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    if (!reset && (r_credit != '0)) begin
      if (r_state == S_IDLE) begin
        for (int k = 0; k < NUM_IN; k++) begin
          w_idx = (int'(r_rr_ptr) + k) % NUM_IN;
          if (!w_found && bus.req[w_idx] && bus.flit_in[w_idx*FLIT_W + FLIT_W-2]) begin
            w_found = 1'b1;
            w_win   = OW'(w_idx);
          end
        end
      end else if (bus.req[r_owner] &&
                   !bus.flit_in[int'(r_owner)*FLIT_W + FLIT_W-2]) begin
        w_found = 1'b1;
        w_win   = r_owner;
      end
    end
  end

  always_comb begin
    w_flit     = bus.flit_in[int'(w_win)*FLIT_W +: FLIT_W];
    w_is_tail  = w_flit[FLIT_W-1];
    w_next_ptr = (w_win == OW'(NUM_IN-1)) ? '0 : w_win + OW'(1);
    for (int i = 0; i < NUM_IN; i++) begin
      w_grant[i] = w_found && (w_win == OW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_credit     <= C_CREDIT_MAX;
      r_flit_out   <= '0;
      r_flit_valid <= 1'b0;
    end else begin
      r_flit_valid <= w_found;
      if (w_found) begin
        r_flit_out <= w_flit;
        case (r_state)
          S_IDLE: begin
            if (w_is_tail) begin
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_owner <= w_win;
              r_state <= S_LOCKED;
            end
          end
          default: begin
            if (w_is_tail) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
        endcase
      end
      // Simultaneous transfer and returned credit cancel out.
      if (w_found && !bus.credit_in) begin
        r_credit <= r_credit - CW'(1);
      end else if (!w_found && bus.credit_in && (r_credit != C_CREDIT_MAX)) begin
        r_credit <= r_credit + CW'(1);
      end
    end
  end

  assign bus.grant      = w_grant;
  assign bus.flit_out   = r_flit_out;
  assign bus.flit_valid = r_flit_valid;
  assign bus.credit_cnt = r_credit;

endmodule

`default_nettype wire

// File: tb/tb_output_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_output_arbiter
// Brief    : Directed scoreboard bench for output_arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  logic [7:0] q[$];

  output_arbiter_if #(.NUM_IN(4), .FLIT_W(8), .CREDITS(4)) bus ();

  output_arbiter #(.NUM_IN(4), .FLIT_W(8), .CREDITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check the combinational grant, then check the registered output.
  task automatic cyc(input logic [3:0] rq, input logic [31:0] fl, input logic ci,
                     input logic [3:0] eg, input int ec);
    logic [7:0] exp_f;
    @(negedge clk);
    bus.req       = rq;
    bus.flit_in   = fl;
    bus.credit_in = ci;
    #1;
    chk("grant", {28'd0, bus.grant}, {28'd0, eg});
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) q.push_back(fl[i*8 +: 8]);
    end
    @(posedge clk);
    #1;
    bus.credit_in = 1'b0;
    chk("flit_valid", {31'd0, bus.flit_valid}, {31'd0, (eg != 4'd0)});
    if (bus.flit_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $error("FAIL scoreboard observed=%0h expected=empty", bus.flit_out);
      end else begin
        exp_f = q.pop_front();
        chk("flit_out", {24'd0, bus.flit_out}, {24'd0, exp_f});
      end
    end
    chk("credit_cnt", {29'd0, bus.credit_cnt}, ec);
  endtask

  task automatic rst_chk(input logic [3:0] rq, input logic [31:0] fl);
    @(negedge clk);
    reset         = 1'b1;
    bus.req       = rq;
    bus.flit_in   = fl;
    bus.credit_in = 1'b0;
    #1;
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.flit_valid}, 32'd0);
    chk("rst_flit_out", {24'd0, bus.flit_out}, 32'd0);
    chk("rst_credit", {29'd0, bus.credit_cnt}, 32'd4);
    q.delete();
    reset   = 1'b0;
    bus.req = 4'd0;
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.req       = 4'd0;
    bus.flit_in   = 32'd0;
    bus.credit_in = 1'b0;
    rst_chk(4'd0, 32'd0);

    // Single flit on input 0, then refill the credit.
    cyc(4'b0001, {8'h00, 8'h00, 8'h00, 8'hC5}, 1'b0, 4'b0001, 3);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 4);

    // Wormhole lock on input 2 while others offer singles.
    cyc(4'b1111, {8'h01, 8'h41, 8'h01, 8'h01}, 1'b1, 4'b0100, 4);
    cyc(4'b1111, {8'hC3, 8'h0A, 8'hC1, 8'hC0}, 1'b1, 4'b0100, 4);
    cyc(4'b1111, {8'hC3, 8'h82, 8'hC1, 8'hC0}, 1'b1, 4'b0100, 4);
    cyc(4'b1111, {8'hC3, 8'hC2, 8'h01, 8'hC0}, 1'b1, 4'b1000, 4);

    // Round-robin among four single-flit requesters.
    for (int n = 0; n < 5; n++) begin
      cyc(4'b1111, {8'hC3, 8'hC2, 8'hC1, 8'hC0}, 1'b1, 4'(1 << (n % 4)), 4);
    end

    // Protocol errors and credit saturation (rr_ptr now 1).
    cyc(4'b0010, {8'h00, 8'h00, 8'h05, 8'h00}, 1'b0, 4'b0000, 4);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 4);
    cyc(4'b0010, {8'h00, 8'h00, 8'h42, 8'h00}, 1'b0, 4'b0010, 3);
    cyc(4'b0010, {8'h00, 8'h00, 8'h43, 8'h00}, 1'b0, 4'b0000, 3);
    cyc(4'b0010, {8'h00, 8'h00, 8'hC1, 8'h00}, 1'b0, 4'b0000, 3);
    cyc(4'b0010, {8'h00, 8'h00, 8'h84, 8'h00}, 1'b0, 4'b0010, 2);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 3);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 4);

    // Credit exhaustion on a 6-flit packet from input 0.
    cyc(4'b0001, {24'd0, 8'h41}, 1'b0, 4'b0001, 3);
    cyc(4'b0001, {24'd0, 8'h10}, 1'b0, 4'b0001, 2);
    cyc(4'b0001, {24'd0, 8'h11}, 1'b0, 4'b0001, 1);
    cyc(4'b0001, {24'd0, 8'h12}, 1'b0, 4'b0001, 0);
    cyc(4'b0001, {24'd0, 8'h13}, 1'b0, 4'b0000, 0);
    cyc(4'b0001, {24'd0, 8'h13}, 1'b1, 4'b0000, 1);
    cyc(4'b0001, {24'd0, 8'h13}, 1'b0, 4'b0001, 0);
    cyc(4'b0001, {24'd0, 8'h94}, 1'b1, 4'b0000, 1);
    cyc(4'b0001, {24'd0, 8'h94}, 1'b1, 4'b0001, 1);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 2);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 3);
    cyc(4'b0000, 32'd0, 1'b1, 4'b0000, 4);

    // Reset while locked on input 3, then a fresh packet from input 3.
    cyc(4'b1000, {8'h47, 24'd0}, 1'b0, 4'b1000, 3);
    rst_chk(4'b1000, {8'h08, 24'd0});
    cyc(4'b1000, {8'h08, 24'd0}, 1'b0, 4'b0000, 4);
    cyc(4'b1000, {8'h4F, 24'd0}, 1'b0, 4'b1000, 3);
    cyc(4'b1000, {8'h8F, 24'd0}, 1'b0, 4'b1000, 2);
    cyc(4'b0000, 32'd0, 1'b0, 4'b0000, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
